// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The loader writes one program byte per accepted handshake, big-endian within each instruction.
package imem_loader_pkg;

    localparam int unsigned MEM_BYTES_DEF   = 32;
    localparam int unsigned INSTR_W         = 32;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_INSTR = INSTR_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Streams a program into the byte-addressed instruction store and stalls the CPU while loading.
// in_valid/in_ready: a byte moves on any cycle where both are high at the rising edge; in_ready never depends on in_valid.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         base_addr,
    input  logic [CNT_W-1:0]    word_count,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [BYTE_W-1:0]   in_data,
    output logic                in_ready,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [BYTE_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                cpu_stall,
    output logic                done,
    output logic                error,
    output logic [CNT_W-1:0]    words_loaded,
    output loader_state_e       dbg_state
);

    localparam logic [33:0] MEM_LIMIT = 34'(MEM_BYTES);
    localparam logic [1:0]  LAST_IDX  = 2'(BYTES_PER_INSTR - 1);

    loader_state_e      state_q, state_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]   words_q, words_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               handshake;
    logic               start_bad;
    logic               last_byte;
    logic [33:0]        end_addr;
    logic [CNT_W-1:0]   words_inc;

    // Range check is done in 34 bits so a large base plus length can never wrap into range.
    assign end_addr  = 34'(base_addr) + (34'(word_count) * 34'(BYTES_PER_INSTR));
    assign start_bad = (base_addr[1:0] != 2'b00) || (end_addr > MEM_LIMIT);

    assign in_ready  = (state_q == ST_LOAD) && !abort;
    assign handshake = in_valid && in_ready;
    assign words_inc = words_q + CNT_W'(1);
    assign last_byte = (byte_idx_q == LAST_IDX) && (words_inc == count_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        byte_idx_d  = byte_idx_q;
        words_d     = words_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        error_d     = error_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d  = 1'b1;
                        error_d = 1'b0;
                    end else if (start_bad) begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        error_d    = 1'b0;
                        words_d    = '0;
                        ptr_d      = base_addr;
                        byte_idx_d = '0;
                        count_d    = word_count;
                        state_d    = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end else if (handshake) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = in_data;
                    ptr_d       = ptr_q + 32'd1;
                    byte_idx_d  = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_IDX) begin
                        words_d = words_inc;
                    end
                    // done is registered so it lines up with the final byte's write strobe.
                    if (last_byte) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            byte_idx_q  <= '0;
            words_q     <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            byte_idx_q  <= byte_idx_d;
            words_q     <= words_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = (state_q != ST_IDLE);
    assign cpu_stall    = busy;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a transaction-level model predicts every write, done pulse and busy level.
// The predicted writes also fill a reference image that is compared with what the loader wrote.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEMB = 32;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     base_addr = '0;
    logic [CW-1:0]   word_count = '0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic [7:0]      in_data = '0;
    logic            in_ready;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [7:0]      mem_wdata;
    logic            busy;
    logic            cpu_stall;
    logic            done;
    logic            error;
    logic [CW-1:0]   words_loaded;
    loader_state_e   dbg_state;

    always #5 clk = ~clk;

    imem_loader #(.MEM_BYTES(MEMB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .cpu_stall(cpu_stall), .done(done), .error(error),
        .words_loaded(words_loaded), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: per-cycle events set by the driver, delayed one edge to match registered outputs.
    logic [39:0] exp_q[$];
    logic [7:0]  ref_mem[MEMB];
    logic [7:0]  store_mem[MEMB];
    logic [7:0]  prog[64];
    logic        exp_hs = 1'b0, exp_done_ev = 1'b0, exp_busy_n = 1'b0;
    logic        exp_we_p = 1'b0, exp_done_p = 1'b0, exp_busy_p = 1'b0;
    logic        mon_en = 1'b0;
    logic        m_error = 1'b0;
    int          m_wl = 0;

    always @(posedge clk) begin
        exp_we_p   <= exp_hs;
        exp_done_p <= exp_done_ev;
        exp_busy_p <= exp_busy_n;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("mem_we", 40'(mem_we), 40'(exp_we_p));
            check("done", 40'(done), 40'(exp_done_p));
            check("busy", 40'(busy), 40'(exp_busy_p));
            check("cpu_stall", 40'(cpu_stall), 40'(exp_busy_p));
            if (mem_we) begin
                check("wr_in_range", 40'(mem_addr < MEMB), 40'd1);
                if (mem_addr < MEMB) store_mem[int'(mem_addr)] = mem_wdata;
                if (exp_q.size() == 0) check("wr_pending", 40'(exp_q.size()), 40'd1);
                else check("wr_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_hs      = 1'b0;
        exp_done_ev = 1'b0;
    endtask

    // kind: 0 = zero-length, 1 = rejected, 2 = load begins
    task automatic do_start(input logic [31:0] b, input int cnt, output int kind);
        start      = 1'b1;
        base_addr  = b;
        word_count = CW'(cnt);
        if (cnt == 0) begin
            kind = 0; exp_done_ev = 1'b1; m_error = 1'b0;
        end else if ((b % 4) != 0 || (longint'(b) + 4 * cnt) > MEMB) begin
            kind = 1; exp_done_ev = 1'b1; m_error = 1'b1;
        end else begin
            kind = 2; m_error = 1'b0; m_wl = 0; exp_busy_n = 1'b1;
        end
        @(negedge clk);
        check("in_ready_idle", 40'(in_ready), 40'd0);
        tick();
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = CW'($urandom);
    endtask

    // gap_mode: 0 back-to-back, 1 valid low every third cycle, 2 random gaps.
    task automatic feed(input logic [31:0] b, input int cnt, input int gap_mode,
                        input int abort_at, input int rst_at, input int start_at);
        int  k = 0;
        int  cyc = 0;
        bit  gap;
        bit  st_used = 1'b0;
        while (k < cnt * 4) begin
            if (cyc > 1000) begin
                check("feed_timeout", 40'(cyc), 40'd0);
                break;
            end
            cyc++;
            abort = 1'b0;
            start = 1'b0;
            if (k == start_at && !st_used) begin
                start = 1'b1; base_addr = 32'h10; word_count = '0; st_used = 1'b1;
            end
            if (k == abort_at) begin
                abort = 1'b1; in_valid = 1'b1; in_data = prog[k];
                exp_done_ev = 1'b1; exp_busy_n = 1'b0; m_error = 1'b1; m_wl = k / 4;
                @(negedge clk);
                check("in_ready_abort", 40'(in_ready), 40'd0);
                tick();
                abort = 1'b0; in_valid = 1'b0;
                return;
            end
            if (k == rst_at) begin
                rst = 1'b1; in_valid = 1'b1; in_data = prog[k];
                exp_busy_n = 1'b0; m_error = 1'b0; m_wl = 0;
                tick();
                rst = 1'b0; in_valid = 1'b0;
                return;
            end
            case (gap_mode)
                0:       gap = 1'b0;
                1:       gap = (cyc % 3 == 0);
                default: gap = ($urandom_range(0, 3) == 0);
            endcase
            in_valid = !gap;
            in_data  = gap ? 8'($urandom) : prog[k];
            if (!gap) begin
                exp_hs = 1'b1;
                exp_q.push_back({b + 32'(k), prog[k]});
                ref_mem[int'(b) + k] = prog[k];
                if (k == cnt * 4 - 1) exp_done_ev = 1'b1;
            end
            @(negedge clk);
            check("in_ready_load", 40'(in_ready), 40'd1);
            tick();
            if (!gap) k++;
        end
        in_valid   = 1'b0;
        start      = 1'b0;
        exp_busy_n = 1'b0;
        m_wl       = cnt;
        tick();
    endtask

    task automatic check_outcome(input string tag);
        check({tag, "_words_loaded"}, 40'(words_loaded), 40'(m_wl));
        check({tag, "_error"}, 40'(error), 40'(m_error));
        check({tag, "_state"}, 40'(dbg_state), 40'(ST_IDLE));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            abort    = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            @(negedge clk);
            check("in_ready_idle", 40'(in_ready), 40'd0);
            tick();
        end
        abort    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int kind;
        int cnt;
        logic [31:0] b;
        for (int i = 0; i < MEMB; i++) begin
            ref_mem[i]   = '0;
            store_mem[i] = '0;
        end

        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        check("rst_mem_addr", 40'(mem_addr), 40'd0);
        check("rst_mem_wdata", 40'(mem_wdata), 40'd0);
        check("rst_error", 40'(error), 40'd0);
        check("rst_words_loaded", 40'(words_loaded), 40'd0);
        check("rst_state", 40'(dbg_state), 40'(ST_IDLE));
        idle_cycles(3);

        // One instruction 0x00235022 at base 4, back-to-back.
        prog[0] = 8'h00; prog[1] = 8'h23; prog[2] = 8'h50; prog[3] = 8'h22;
        do_start(32'd4, 1, kind);
        check("t1_kind", 40'(kind), 40'd2);
        feed(32'd4, 1, 0, -1, -1, -1);
        check_outcome("t1");

        // Five instructions at base 4 with a gap every third cycle.
        {prog[0], prog[1], prog[2], prog[3]}     = 32'h00A38822;
        {prog[4], prog[5], prog[6], prog[7]}     = 32'h00A38824;
        {prog[8], prog[9], prog[10], prog[11]}   = 32'h00A38825;
        {prog[12], prog[13], prog[14], prog[15]} = 32'h00A38820;
        {prog[16], prog[17], prog[18], prog[19]} = 32'hAC850004;
        do_start(32'd4, 5, kind);
        feed(32'd4, 5, 1, -1, -1, -1);
        check_outcome("t2");

        // Rejected starts, then a good one clears error.
        do_start(32'd2, 1, kind);
        check_outcome("t3_misaligned");
        idle_cycles(2);
        do_start(32'd28, 2, kind);
        check_outcome("t3_overrun");
        do_start(32'd28, 1, kind);
        check("t3_edge_error", 40'(error), 40'd0);
        for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
        feed(32'd28, 1, 0, -1, -1, -1);
        check_outcome("t3_edge");

        // Abort after six bytes of a three-word load at base 8.
        for (int i = 0; i < 12; i++) prog[i] = 8'($urandom);
        do_start(32'd8, 3, kind);
        feed(32'd8, 3, 0, 6, -1, -1);
        check_outcome("t4");
        idle_cycles(2);

        // Reset after three bytes, then a clean one-word load at base 0.
        do_start(32'd0, 2, kind);
        feed(32'd0, 2, 0, -1, 3, -1);
        check("t5_mem_addr", 40'(mem_addr), 40'd0);
        check("t5_mem_wdata", 40'(mem_wdata), 40'd0);
        check_outcome("t5_rst");
        for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
        do_start(32'd0, 1, kind);
        feed(32'd0, 1, 2, -1, -1, -1);
        check_outcome("t5_reload");

        // start during LOAD is ignored; zero-length start clears error without writes.
        for (int i = 0; i < 4; i++) prog[i] = 8'($urandom);
        do_start(32'd12, 1, kind);
        feed(32'd12, 1, 0, -1, -1, 2);
        check_outcome("t6_ignored_start");
        do_start(32'd1, 3, kind);
        check_outcome("t6_err");
        do_start(32'd0, 0, kind);
        check("t6_zero_error", 40'(error), 40'd0);
        idle_cycles(2);

        // Randomized loads, rejected starts and aborts.
        for (int it = 0; it < 40; it++) begin
            cnt = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 1) b = 32'(4 * $urandom_range(0, 8));
            else b = 32'($urandom_range(0, 36));
            for (int i = 0; i < 40; i++) prog[i] = 8'($urandom);
            do_start(b, cnt, kind);
            if (kind == 2) begin
                if ($urandom_range(0, 3) == 0) feed(b, cnt, 2, $urandom_range(0, cnt * 4 - 1), -1, -1);
                else feed(b, cnt, 2, -1, -1, -1);
                check_outcome("rnd_load");
            end else begin
                check("rnd_start_error", 40'(error), 40'(m_error));
            end
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(2);
        check("pending_writes", 40'(exp_q.size()), 40'd0);
        for (int i = 0; i < MEMB; i++) check("mem_image", 40'(store_mem[i]), 40'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
